// File: rtl/button_event.sv
// button_event: debounced button level to one-cycle press/release/click/double/long/repeat pulses.
// Auto-repeat is built only with BUTTON_EVENT_REPEAT_EN; release/repeat are SV keywords, hence release_pulse/repeat_pulse.
module button_event #(
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int DCLICK_CYCLES = 25_000_000,
   parameter int REPEAT_CYCLES = 10_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic in,
   output logic press,
   output logic release_pulse,
   output logic single_click,
   output logic double_click,
   output logic long_press,
   output logic repeat_pulse
);
   localparam int MAX_LD = (LONG_CYCLES > DCLICK_CYCLES) ? LONG_CYCLES : DCLICK_CYCLES;
   localparam int MAX_ALL = (MAX_LD > REPEAT_CYCLES) ? MAX_LD : REPEAT_CYCLES;
   localparam int CW = $clog2(MAX_ALL);
   localparam logic [CW-1:0] LONG_T = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] DCLICK_T = CW'(DCLICK_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic in_d_q;
   logic rise, fall;
   logic [4:0] ev_q, ev_d;
   logic rpt_d;
   assign rise = in & ~in_d_q;
   assign fall = ~in & in_d_q;
   // ev bits: {press, release, single_click, double_click, long_press}
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ev_d = '0;
      rpt_d = 1'b0;
      case (state_q)
         IDLE: if (rise) begin
            ev_d[4] = 1'b1;
            state_d = PRESSED;
         end
         PRESSED: if (fall) begin
            ev_d[3] = 1'b1;
            state_d = WAIT_SECOND;
         end else if (count_q == LONG_T) begin
            ev_d[0] = 1'b1;
            state_d = LONG_HELD;
         end else count_d = count_q + 1'b1;
         LONG_HELD: if (fall) begin
            ev_d[3] = 1'b1;
            state_d = IDLE;
         end
`ifdef BUTTON_EVENT_REPEAT_EN
         else if (count_q == CW'(REPEAT_CYCLES - 1)) begin
            rpt_d = 1'b1;
            count_d = '0;
         end else count_d = count_q + 1'b1;
`endif
         WAIT_SECOND: if (rise) begin
            ev_d[4] = 1'b1;
            ev_d[1] = 1'b1;
            state_d = SECOND_PRESSED;
         end else if (count_q == DCLICK_T) begin
            ev_d[2] = 1'b1;
            state_d = IDLE;
         end else count_d = count_q + 1'b1;
         SECOND_PRESSED: if (fall) begin
            ev_d[3] = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      count_d = (state_d != state_q) ? '0 : count_d;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         in_d_q <= 1'b0;
         ev_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         in_d_q <= in;
         ev_q <= ev_d;
      end
   end
`ifdef BUTTON_EVENT_REPEAT_EN
   logic rpt_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) rpt_q <= 1'b0;
      else rpt_q <= rpt_d;
   end
   assign repeat_pulse = rpt_q;
`else
   logic unused_rpt;
   assign unused_rpt = rpt_d;
   assign repeat_pulse = 1'b0;
`endif
   assign {press, release_pulse, single_click, double_click, long_press} = ev_q;
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed stimulus with scoreboard of expected pulse edges, checked by a negedge monitor.
module tb_button_event;
   localparam logic [5:0] P = 6'b100000, R = 6'b010000, S = 6'b001000;
   localparam logic [5:0] D = 6'b000100, L = 6'b000010, RP = 6'b000001;
   logic clk = 1'b0, reset = 1'b1, in = 1'b0;
   logic press, release_pulse, single_click, double_click, long_press, repeat_pulse;
   logic [5:0] outs;
   int cyc = 0, total = 0, bad = 0, t0, t1;
   typedef struct {int t; logic [5:0] v;} ev_t;
   ev_t q[$];
   button_event #(.LONG_CYCLES(8), .DCLICK_CYCLES(6), .REPEAT_CYCLES(4)) dut (
      .clock(clk), .reset(reset), .in(in), .press(press), .release_pulse(release_pulse),
      .single_click(single_click), .double_click(double_click), .long_press(long_press),
      .repeat_pulse(repeat_pulse)
   );
   assign outs = {press, release_pulse, single_click, double_click, long_press, repeat_pulse};
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (!reset && outs != 6'b0) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse edge=%0d got=%b want=none", cyc, outs);
         end else begin
            ev_t e;
            e = q.pop_front();
            if (e.t != cyc || e.v != outs) begin
               bad++;
               $display("FAIL pulse edge=%0d got=%b want edge=%0d %b", cyc, outs, e.t, e.v);
            end
         end
      end
   end
   task automatic expect_ev(input int t, input logic [5:0] v);
      ev_t e;
      e.t = t;
      e.v = v;
      q.push_back(e);
   endtask
   task automatic drive(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         in = v;
         @(negedge clk);
      end
   endtask
   task automatic start(output int t);
      @(negedge clk);
      t = cyc + 1;
   endtask
   task automatic check_zero(input string name);
      total++;
      if (outs != 6'b0) begin
         bad++;
         $display("FAIL %s got=%b want=000000", name, outs);
      end
   endtask
   initial begin
      #1 check_zero("reset_outputs");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      // short click -> single_click
      start(t0);
      expect_ev(t0, P); expect_ev(t0 + 3, R); expect_ev(t0 + 9, S);
      drive(1, 3); drive(0, 12);
      // double click
      start(t0);
      expect_ev(t0, P); expect_ev(t0 + 3, R); expect_ev(t0 + 7, P | D); expect_ev(t0 + 9, R);
      drive(1, 3); drive(0, 4); drive(1, 2); drive(0, 6);
      // long hold with repeats
      start(t0);
      expect_ev(t0, P); expect_ev(t0 + 8, L);
`ifdef BUTTON_EVENT_REPEAT_EN
      expect_ev(t0 + 12, RP); expect_ev(t0 + 16, RP); expect_ev(t0 + 20, RP);
`endif
      expect_ev(t0 + 21, R);
      drive(1, 21); drive(0, 4);
      // fall on the long-press terminal cycle stays a short press
      start(t0);
      expect_ev(t0, P); expect_ev(t0 + 8, R); expect_ev(t0 + 14, S);
      drive(1, 8); drive(0, 10);
      // second rise on the double-click timeout cycle wins
      start(t0);
      expect_ev(t0, P); expect_ev(t0 + 3, R); expect_ev(t0 + 9, P | D); expect_ev(t0 + 11, R);
      drive(1, 3); drive(0, 6); drive(1, 2); drive(0, 4);
      // reset during LONG_HELD while long_press is still high
      start(t0);
      expect_ev(t0, P); expect_ev(t0 + 8, L);
      drive(1, 9);
      #1 reset = 1'b1;
      #1 check_zero("async_reset_clears");
      @(negedge clk);
      check_zero("reset_hold");
      @(negedge clk);
      t1 = cyc + 1;
      expect_ev(t1, P); expect_ev(t1 + 8, L); expect_ev(t1 + 10, R);
      #1 reset = 1'b0;
      @(negedge clk);
      drive(1, 9); drive(0, 6);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL missing_pulses left=%0d want=0 next_edge=%0d next=%b", q.size(), q[0].t, q[0].v);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
